fc_stream_layer: RTL and testbench
==================================

// Module: fc_stream_layer
// PURPOSE
//  Parametrised fully-connected layer y = f(W*x), W is M x N, with P parallel MAC lanes.
//  Input vector memory is ping-pong double-buffered, so vector k+1 loads while vector k computes.
//  Weights come from an external synchronous ROM port. Optional ReLU.
//  Sits between two valid/ready streams in the layer chain.
// PARAMETERS
//  M     8           output rows; M % P == 0 required (elaboration $error otherwise)
//  N     8           input vector length, >= 2
//  T     16          signed data/weight width
//  R     1           1 = ReLU on outputs, 0 = none
//  P     2           parallel MAC lanes (rows computed per group), 1..M
//  ACCW  2*T+$clog2(N)  internal accumulator width (derived localparam, not overridable)
// PORTS
//  clk           in   1                  clock, rising edge
//  reset         in   1                  asynchronous, active-high
//  input_valid   in   1                  input_data valid
//  input_ready   out  1                  block can accept input_data
//  input_data    in   T                  signed x element, element 0 first
//  w_addr        out  $clog2(M/P*N)      weight ROM address = group*N + k
//  w_data        in   P*T                lane p weight W[group*P+p][k] at [p*T +: T]; valid 1 cycle after w_addr
//  output_valid  out  1                  output_data valid
//  output_ready  in   1                  downstream accepts output_data
//  output_data   out  T                  signed y element, row 0 first
// BEHAVIOUR
//  Reset (async, any state): input_ready=0, output_valid=0, output_data=0, w_addr=0; both banks
//   empty; all counters, accumulators and FSMs cleared. input_ready rises on the first clk after release.
//  Load side: transfer when input_valid && input_ready. Writes x into current load bank at count 0..N-1.
//   After the Nth write, the bank is marked full and load switches to the other bank.
//   input_ready = load bank not full. Both banks full -> input_ready=0.
//  Compute FSM states: IDLE, MAC, FLUSH, EMIT.
//   IDLE -> MAC when the compute bank is full.
//   MAC issues k=0..N-1 (x addr k, w_addr group*N+k) for N cycles.
//   Pipeline: sync read (1), product reg (1), accumulate (1).
//   MAC -> FLUSH for 3 cycles. Then each lane accumulator is saturated to T and ReLU'd if R, latched into
//    an output buffer, and the FSM goes to EMIT.
//   EMIT: presents lanes 0..P-1 in order. output_valid=1; advance on output_valid && output_ready.
//    After lane P-1 with group < M/P-1: group++, accumulators cleared, -> MAC.
//    After the last group: compute bank marked empty, compute bank toggles, -> IDLE (or MAC if the other bank is full).
//  Latency: first output_valid exactly N+3 cycles after MAC entry; MAC entry is the cycle after bank-full.
//  Throughput: output_ready held high gives M/P*(N+3+P) cycles per vector. Load overlaps compute.
//  Arithmetic: full 2T-bit product, ACCW-bit accumulate (cannot overflow).
//   Single saturation to [-2^(T-1), 2^(T-1)-1] at output, then ReLU (negative -> 0).
//  Boundaries:
//   - Simultaneous load-bank-full and compute-bank-release in one cycle: both take effect; no element is lost.
//   - output_ready low: FSM holds in EMIT and output_data stays stable; loading continues until both banks are full.
//   - P == M: single group. P == 1: one output per group.
//   - Counters wrap to 0 only on their terminal event, never by overflow.
//   - output_data is stable while output_valid && !output_ready.
// STRUCTURE
//  Package fc_pkg:
//   - typedef enum {IDLE, MAC, FLUSH, EMIT} fc_state_t
//   - function sat_relu(acc, R) returning T bits
//   - localparam helper $clog2 wrappers
//  Sub-module fc_mac_lane (T, ACCW) holds the product reg, accumulator, clear and enable.
//   Instantiated P times in a generate loop.
//  The x ping-pong is 2 x N x T registers inside this module. Control is a single always_ff FSM plus counters.
// TESTING (M=8, N=8, T=16, P=2 unless stated)
//  1. W=identity, x=1..8, output_ready=1 -> y=1..8 in order; first output_valid N+3=11 cycles after MAC entry.
//  2. All W=32767, x all 32767 -> every y=32767 (saturated). All W=-32767: R=1 -> y=0; R=0 -> y=-32768.
//  3. Three vectors back-to-back, output_ready=0:
//     -> input_ready drops after the 16th element; rises after output_ready=1 and the first vector's 8 outputs.
//  4. Random W/x, output_ready random 50% -> y matches golden model bit-exactly.
//     Output order is preserved and output_data is stable across stalls.
//  5. Assert reset mid-MAC of group 2 -> outputs 0 immediately (async).
//     The next vector after release computes correctly with no stale accumulation.
//  6. P=1 and P=8 (M=8) builds with random data -> golden match; P=8 emits 8 outputs after a single N+3 window.

Source files
------------

// File: rtl/fc_pkg.sv
// fc_pkg: shared state type and arithmetic helpers for the fully-connected stream layer
package fc_pkg;
  typedef enum logic [1:0] {IDLE, MAC, FLUSH, EMIT} fc_state_t;
  localparam int SAT_W = 64;
  function automatic int clog2p(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction
  // Saturate a wide accumulator into t signed bits, then optionally clamp negatives to zero.
  function automatic logic signed [SAT_W-1:0] sat_relu(input logic signed [SAT_W-1:0] acc, input int t, input bit r);
    logic signed [SAT_W-1:0] hi, lo, s;
    hi = (64'sd1 <<< (t - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (t - 1));
    s = (acc > hi) ? hi : (acc < lo) ? lo : acc;
    return (r && s < 0) ? '0 : s;
  endfunction
endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one MAC lane, registered full-width product feeding a restartable accumulator
module fc_mac_lane #(
  parameter int T = 16,
  parameter int ACCW = 35
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vld_i,
  input  logic                   first_i,
  input  logic signed [T-1:0]    x_i,
  input  logic signed [T-1:0]    w_i,
  output logic signed [ACCW-1:0] acc_o
);
  logic signed [2*T-1:0] prod_q;
  logic signed [ACCW-1:0] acc_q;
  logic pv_q, pf_q;
  assign acc_o = acc_q;
  // The first product of a row restarts the sum, so no separate clear pulse is needed.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prod_q <= '0;
      pv_q <= 1'b0;
      pf_q <= 1'b0;
      acc_q <= '0;
    end else begin
      prod_q <= (2*T)'(x_i) * (2*T)'(w_i);
      pv_q <= vld_i;
      pf_q <= first_i;
      if (pv_q) acc_q <= (pf_q ? '0 : acc_q) + ACCW'(prod_q);
    end
endmodule

// File: rtl/fc_stream_layer.sv
// fc_stream_layer: streaming y = f(W*x) with ping-pong input banks and P parallel MAC lanes
module fc_stream_layer import fc_pkg::*; #(
  parameter int M = 8,
  parameter int N = 8,
  parameter int T = 16,
  parameter int R = 1,
  parameter int P = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          input_valid,
  output logic                          input_ready,
  input  logic signed [T-1:0]           input_data,
  output logic [clog2p(M/P*N)-1:0]      w_addr,
  input  logic [P*T-1:0]                w_data,
  output logic                          output_valid,
  input  logic                          output_ready,
  output logic signed [T-1:0]           output_data
);
  localparam int ACCW = 2*T + $clog2(N);
  localparam int G = M / P;
  localparam int AW = clog2p(G*N);
  localparam int GW = clog2p(G);
  localparam int XW = clog2p(N);
  localparam int PW = clog2p(P);
  localparam int MX = (N > P) ? ((N > 3) ? N : 3) : ((P > 3) ? P : 3);
  localparam int CW = clog2p(MX);
  if (M % P != 0 || N < 2) begin : g_chk
    $error("fc_stream_layer: M must be a multiple of P and N must be at least 2");
  end
  fc_state_t st_q, st_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] full_q, full_d;
  logic cb_q, cb_d, ld_bank_q, rdy_q, rv_q, rf_q, rel, latch, ld_fire, ld_last;
  logic [XW-1:0] ld_cnt_q;
  logic signed [T-1:0] xb_q [2][N];
  logic signed [T-1:0] xr_q;
  logic signed [T-1:0] ob_q [P];
  logic signed [ACCW-1:0] acc [P];
  assign input_ready = rdy_q && !full_q[ld_bank_q];
  assign ld_fire = input_valid && input_ready;
  assign ld_last = ld_fire && ld_cnt_q == XW'(N-1);
  assign output_valid = st_q == EMIT;
  assign output_data = output_valid ? ob_q[cnt_q[PW-1:0]] : '0;
  assign w_addr = (st_q == MAC) ? AW'(int'(grp_q) * N + int'(cnt_q)) : '0;
  // cnt_q is reused as k index in MAC, flush timer in FLUSH and lane index in EMIT.
  always_comb begin
    st_d = st_q;
    grp_d = grp_q;
    cnt_d = cnt_q;
    cb_d = cb_q;
    rel = 1'b0;
    latch = 1'b0;
    case (st_q)
      IDLE: st_d = full_q[cb_q] ? MAC : IDLE;
      MAC: begin
        cnt_d = (cnt_q == CW'(N-1)) ? '0 : cnt_q + 1'b1;
        st_d = (cnt_q == CW'(N-1)) ? FLUSH : MAC;
      end
      FLUSH: begin
        latch = cnt_q == CW'(2);
        cnt_d = latch ? '0 : cnt_q + 1'b1;
        st_d = latch ? EMIT : FLUSH;
      end
      EMIT: if (output_ready) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(P-1)) begin
          cnt_d = '0;
          rel = grp_q == GW'(G-1);
          grp_d = rel ? '0 : grp_q + 1'b1;
          cb_d = rel ? !cb_q : cb_q;
          st_d = (!rel || full_q[!cb_q]) ? MAC : IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
    full_d = full_q;
    if (ld_last) full_d[ld_bank_q] = 1'b1;
    if (rel) full_d[cb_q] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= IDLE;
      grp_q <= '0;
      cnt_q <= '0;
      cb_q <= 1'b0;
      full_q <= '0;
      ld_bank_q <= 1'b0;
      ld_cnt_q <= '0;
      rdy_q <= 1'b0;
      rv_q <= 1'b0;
      rf_q <= 1'b0;
      for (int p = 0; p < P; p++) ob_q[p] <= '0;
    end else begin
      st_q <= st_d;
      grp_q <= grp_d;
      cnt_q <= cnt_d;
      cb_q <= cb_d;
      full_q <= full_d;
      rdy_q <= 1'b1;
      if (ld_fire) begin
        ld_cnt_q <= ld_last ? '0 : ld_cnt_q + 1'b1;
        ld_bank_q <= ld_bank_q ^ ld_last;
      end
      rv_q <= st_q == MAC;
      rf_q <= st_q == MAC && cnt_q == '0;
      if (latch) for (int p = 0; p < P; p++) ob_q[p] <= T'(sat_relu(SAT_W'(acc[p]), T, R != 0));
    end
  // x read is registered so it lines up with the one-cycle weight ROM latency.
  always_ff @(posedge clk) begin
    if (ld_fire) xb_q[ld_bank_q][ld_cnt_q] <= input_data;
    xr_q <= xb_q[cb_q][cnt_q[XW-1:0]];
  end
  for (genvar l = 0; l < P; l++) begin : g_lane
    fc_mac_lane #(.T(T), .ACCW(ACCW)) u_lane (
      .clk(clk),
      .reset(reset),
      .vld_i(rv_q),
      .first_i(rf_q),
      .x_i(xr_q),
      .w_i($signed(w_data[l*T +: T])),
      .acc_o(acc[l])
    );
  end
endmodule

// File: tb/tb_fc_stream_layer.sv
// tb_fc_stream_layer: randomized scenarios on P=2/R=1, P=1/R=0 and P=8/R=1 builds against a matrix model
module tb_fc_stream_layer;
  localparam int M = 8, N = 8, T = 16;
  localparam int PC [3] = '{2, 1, 8};
  localparam int RC [3] = '{1, 0, 1};
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic iv [3], ir [3], ov [3], ordy [3];
  logic [T-1:0] id [3], od [3];
  logic [5:0] wa [3];
  int wm [3][M][N];
  int xv [3][4][N];
  int got [3][$];
  int exq [3][$];
  int checks = 0, failures = 0;
  int to_cnt, stab_err, first_ov, last_acc, out8_cyc, v3_first;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int PP = PC[g];
    localparam int AW = $clog2(M / PP * N);
    logic [AW-1:0] a;
    logic [PP*T-1:0] w;
    assign wa[g] = 6'(a);
    always @(posedge clk)
      for (int p = 0; p < PP; p++) w[p*T +: T] <= T'(wm[g][(int'(a) / N) * PP + p][int'(a) % N]);
    fc_stream_layer #(.M(M), .N(N), .T(T), .R(RC[g]), .P(PP)) u_dut (
      .clk(clk), .reset(reset),
      .input_valid(iv[g]), .input_ready(ir[g]), .input_data(id[g]),
      .w_addr(a), .w_data(w),
      .output_valid(ov[g]), .output_ready(ordy[g]), .output_data(od[g])
    );
  end
  function automatic int model(input int i, input int v, input int row);
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(wm[i][row][k]) * longint'(xv[i][v][k]);
    s = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
    if (RC[i] != 0 && s < 0) s = 0;
    return int'(s);
  endfunction
  function automatic int rnd(input int lim);
    return int'($urandom_range(2 * lim)) - lim;
  endfunction
  task automatic push_exp(input int i, input int v);
    for (int r = 0; r < M; r++) exq[i].push_back(model(i, v, r));
  endtask
  task automatic fill_rand(input int i, input int nv);
    for (int r = 0; r < M; r++) for (int k = 0; k < N; k++) wm[i][r][k] = rnd(100);
    for (int v = 0; v < nv; v++) for (int k = 0; k < N; k++) xv[i][v][k] = rnd(300);
  endtask
  task automatic start(input int i);
    got[i].delete();
    exq[i].delete();
    to_cnt = 0;
    stab_err = 0;
  endtask
  task automatic feed(input int i, input int v0, input int nv);
    for (int v = v0; v < v0 + nv; v++) for (int k = 0; k < N; k++) begin
      int b;
      logic ok;
      b = 0;
      iv[i] = 1'b1;
      id[i] = T'(xv[i][v][k]);
      do begin
        ok = ir[i];
        @(posedge clk); #1;
        b++;
      end while (!ok && b < 3000);
      if (!ok) to_cnt++;
      last_acc = cyc;
      if (v == 2 && k == 0) v3_first = cyc;
    end
    iv[i] = 1'b0;
  endtask
  task automatic collect(input int i, input int n, input int pct);
    int b, cnt;
    logic hold;
    logic [T-1:0] hv;
    b = 0; cnt = 0; hold = 1'b0; hv = '0; first_ov = -1;
    while (cnt < n && b < 5000) begin
      ordy[i] = $urandom_range(99) < pct;
      if (hold && (!ov[i] || od[i] !== hv)) stab_err++;
      if (ov[i] && first_ov < 0) first_ov = cyc;
      if (ov[i] && ordy[i]) begin
        got[i].push_back(int'($signed(od[i])));
        cnt++;
        if (cnt == 8) out8_cyc = cyc;
      end
      hold = ov[i] && !ordy[i];
      hv = od[i];
      @(posedge clk); #1;
      b++;
    end
    ordy[i] = 1'b0;
    if (cnt < n) to_cnt++;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; id[i] = '0; end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ir[i] !== 1'b0 || ov[i] !== 1'b0 || od[i] !== '0 || wa[i] !== '0) begin
        failures++;
        $display("FAIL reset_state dut%0d ir=%b ov=%b od=%h wa=%h required 0", i, ir[i], ov[i], od[i], wa[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (ir[0] !== 1'b0) begin failures++; $display("FAIL ready_before_clk got=%b required 0", ir[0]); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ir[i] !== 1'b1) begin failures++; $display("FAIL ready_after_release dut%0d got=%b required 1", i, ir[i]); end
    end
  endtask
  task automatic test_identity;
    start(0);
    for (int r = 0; r < M; r++) for (int k = 0; k < N; k++) wm[0][r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < N; k++) xv[0][0][k] = k + 1;
    feed(0, 0, 1);
    collect(0, 8, 100);
    checks++;
    if (first_ov - last_acc !== N + 4) begin
      failures++;
      $display("FAIL ident_latency got=%0d required=%0d edges after last load", first_ov - last_acc, N + 4);
    end
    for (int j = 0; j < M; j++) begin
      int gv;
      gv = (j < got[0].size()) ? got[0][j] : 32'h7fffffff;
      checks++;
      if (gv !== j + 1) begin failures++; $display("FAIL ident_y%0d got=%0d required=%0d", j, gv, j + 1); end
    end
    checks++;
    if (to_cnt !== 0) begin failures++; $display("FAIL ident_timeout got=%0d required=0", to_cnt); end
  endtask
  task automatic test_saturation;
    int req [3];
    req = '{32767, 0, -32768};
    for (int c = 0; c < 3; c++) begin
      int i;
      i = (c == 2) ? 1 : 0;
      start(i);
      for (int r = 0; r < M; r++) for (int k = 0; k < N; k++) wm[i][r][k] = (c == 0) ? 32767 : -32767;
      for (int k = 0; k < N; k++) xv[i][0][k] = 32767;
      feed(i, 0, 1);
      collect(i, 8, 100);
      for (int j = 0; j < M; j++) begin
        int gv;
        gv = (j < got[i].size()) ? got[i][j] : 32'h7fffffff;
        checks++;
        if (gv !== req[c]) begin failures++; $display("FAIL sat%0d_y%0d got=%0d required=%0d", c, j, gv, req[c]); end
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [T-1:0] held;
    int bad;
    start(0);
    fill_rand(0, 3);
    for (int v = 0; v < 3; v++) push_exp(0, v);
    ordy[0] = 1'b0;
    feed(0, 0, 2);
    checks++;
    if (ir[0] !== 1'b0) begin failures++; $display("FAIL b2b_ready_after16 got=%b required 0", ir[0]); end
    repeat (30) begin @(posedge clk); #1; end
    held = od[0];
    bad = 0;
    repeat (20) begin
      if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || od[0] !== held) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL b2b_hold bad_cycles=%0d required 0", bad); end
    fork
      feed(0, 2, 1);
      collect(0, 24, 100);
    join
    checks++;
    if (v3_first <= out8_cyc) begin
      failures++;
      $display("FAIL b2b_third_load got_cycle=%0d required after %0d", v3_first, out8_cyc);
    end
    for (int j = 0; j < 24; j++) begin
      int gv;
      gv = (j < got[0].size()) ? got[0][j] : 32'h7fffffff;
      checks++;
      if (gv !== exq[0][j]) begin failures++; $display("FAIL b2b_y%0d got=%0d required=%0d", j, gv, exq[0][j]); end
    end
    checks++;
    if (to_cnt !== 0) begin failures++; $display("FAIL b2b_timeout got=%0d required=0", to_cnt); end
  endtask
  task automatic test_random_stall;
    start(0);
    fill_rand(0, 3);
    for (int v = 0; v < 3; v++) push_exp(0, v);
    fork
      feed(0, 0, 3);
      collect(0, 24, 50);
    join
    for (int j = 0; j < 24; j++) begin
      int gv;
      gv = (j < got[0].size()) ? got[0][j] : 32'h7fffffff;
      checks++;
      if (gv !== exq[0][j]) begin failures++; $display("FAIL rand_y%0d got=%0d required=%0d", j, gv, exq[0][j]); end
    end
    checks++;
    if (stab_err !== 0 || to_cnt !== 0) begin
      failures++;
      $display("FAIL rand_stability unstable=%0d timeouts=%0d required 0", stab_err, to_cnt);
    end
  endtask
  task automatic test_reset_mid;
    int b;
    start(0);
    fill_rand(0, 2);
    feed(0, 0, 1);
    ordy[0] = 1'b1;
    b = 0;
    while (wa[0] !== 6'(2 * N + 3) && b < 500) begin @(posedge clk); #1; b++; end
    checks++;
    if (b >= 500) begin failures++; $display("FAIL rstmid_reach got_addr=%0d required=%0d", wa[0], 2 * N + 3); end
    ordy[0] = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (wa[0] !== '0 || ov[0] !== 1'b0 || od[0] !== '0 || ir[0] !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async wa=%0d ov=%b od=%h ir=%b required 0", wa[0], ov[0], od[0], ir[0]);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) xv[0][0][k] = xv[0][1][k];
    push_exp(0, 0);
    feed(0, 0, 1);
    collect(0, 8, 100);
    for (int j = 0; j < M; j++) begin
      int gv;
      gv = (j < got[0].size()) ? got[0][j] : 32'h7fffffff;
      checks++;
      if (gv !== exq[0][j]) begin failures++; $display("FAIL rstmid_y%0d got=%0d required=%0d", j, gv, exq[0][j]); end
    end
  endtask
  task automatic test_lanes;
    for (int i = 1; i < 3; i++) begin
      start(i);
      fill_rand(i, 2);
      for (int v = 0; v < 2; v++) push_exp(i, v);
      if (i == 2) begin
        feed(i, 0, 1);
        collect(i, 8, 100);
        checks++;
        if (first_ov - last_acc !== N + 4 || out8_cyc - first_ov !== 7) begin
          failures++;
          $display("FAIL p8_timing latency=%0d span=%0d required %0d and 7", first_ov - last_acc, out8_cyc - first_ov, N + 4);
        end
        feed(i, 1, 1);
        collect(i, 8, 50);
      end else begin
        fork
          feed(i, 0, 2);
          collect(i, 16, 50);
        join
      end
      for (int j = 0; j < 16; j++) begin
        int gv;
        gv = (j < got[i].size()) ? got[i][j] : 32'h7fffffff;
        checks++;
        if (gv !== exq[i][j]) begin failures++; $display("FAIL p%0d_y%0d got=%0d required=%0d", PC[i], j, gv, exq[i][j]); end
      end
      checks++;
      if (stab_err !== 0 || to_cnt !== 0) begin
        failures++;
        $display("FAIL p%0d_stability unstable=%0d timeouts=%0d required 0", PC[i], stab_err, to_cnt);
      end
    end
  endtask
  initial begin
    test_reset;
    test_identity;
    test_saturation;
    test_back_to_back;
    test_random_stall;
    test_reset_mid;
    test_lanes;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
